// File: rtl/hyper_trans_arbiter.sv
// ---------------------------------------------------------------------------
// hyper_trans_arbiter
//
// Purpose:
//   Shares the single HyperBus transaction unpack/issue path between NB_CH
//   independent requesters. Requesters are picked round-robin. The winner's
//   packed descriptor is registered and forwarded downstream with the
//   winner's index as an ID tag. Only one transaction is outstanding at a
//   time. The arbiter grants nothing new until the datapath reports
//   completion. That completion is then returned to the owning requester as
//   a one-cycle done pulse.
//
// Optional feature:
//   HYPER_ARB_TIMEOUT_EN - when defined, a watchdog aborts a BUSY transaction
//   that has not completed within TIMEOUT_CYCLES cycles. It pulses
//   timeout_o together with the owner's done pulse. When undefined,
//   timeout_o is tied low and BUSY waits for trans_done_i indefinitely.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   req_valid_i    per-requester descriptor valid
//   req_ready_o    per-requester accept (combinational, one-hot or zero)
//   req_desc_i     packed descriptors, requester k at [k*DESC_W +: DESC_W]
//   req_done_o     one-cycle completion pulse to the owning requester
//   trans_valid_o  descriptor valid toward the unpack stage
//   trans_ready_i  unpack stage accepts the descriptor
//   trans_desc_o   registered descriptor of the granted requester
//   trans_id_o     index of the granted requester
//   trans_done_i   one-cycle pulse from the datapath: transaction finished
//   busy_o         high while a transaction is being issued or executed
//   timeout_o      one-cycle watchdog pulse (constant 0 without the feature)
// ---------------------------------------------------------------------------
module hyper_trans_arbiter #(
   parameter int NB_CH          = 4,
   parameter int DESC_W         = 128,
   parameter int ID_WIDTH       = $clog2(NB_CH),
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_CH-1:0]          req_valid_i,
   output logic [NB_CH-1:0]          req_ready_o,
   input  logic [NB_CH*DESC_W-1:0]   req_desc_i,
   output logic [NB_CH-1:0]          req_done_o,
   output logic                      trans_valid_o,
   input  logic                      trans_ready_i,
   output logic [DESC_W-1:0]         trans_desc_o,
   output logic [ID_WIDTH-1:0]       trans_id_o,
   input  logic                      trans_done_i,
   output logic                      busy_o,
   output logic                      timeout_o
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;

   // Elaboration-time guard against unusable configurations
   if (NB_CH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("hyper_trans_arbiter: NB_CH must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]          state_q,       state_d;
   logic [ID_WIDTH-1:0] last_grant_q,  last_grant_d;
   logic                trans_valid_q, trans_valid_d;
   logic [DESC_W-1:0]   trans_desc_q,  trans_desc_d;
   logic [ID_WIDTH-1:0] trans_id_q,    trans_id_d;
   logic [NB_CH-1:0]    req_done_q,    req_done_d;

   logic                win_found;
   logic [ID_WIDTH-1:0] win_idx;
   logic [ID_WIDTH-1:0] cand;
   logic [DESC_W-1:0]   desc_arr [NB_CH];

`ifdef HYPER_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                timeout_q, timeout_d;
`endif

   // Split the flat descriptor bus into one slice per requester so the
   // winner's descriptor can be selected by index.
   for (genvar k = 0; k < NB_CH; k++) begin : g_desc_split
      assign desc_arr[k] = req_desc_i[k*DESC_W +: DESC_W];
   end

   // Round-robin search. Candidates are visited starting just after the
   // last served requester and wrapping modulo NB_CH. The last served
   // requester is visited last, so it waits behind everyone else pending.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NB_CH; i++) begin
         cand = ID_WIDTH'((int'(last_grant_q) + i) % NB_CH);
         if (!win_found && req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Accept is offered only in IDLE. It is also forced low while reset is
   // asserted, so that every output reads zero during an abort even if
   // requesters keep their valids high.
   always_comb begin
      req_ready_o = '0;
      if (!rst_i && state_q == ST_IDLE && win_found) begin
         req_ready_o[win_idx] = 1'b1;
      end
   end

   // Next-state logic. Completion is handled in one place. A transaction
   // can finish through trans_done_i or, with the watchdog built in,
   // through a timeout. Either way the owner gets its done pulse and the
   // round-robin pointer moves to it. A trans_done_i on the same cycle as
   // the watchdog limit counts as normal completion, so no timeout is
   // raised.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      trans_valid_d = trans_valid_q;
      trans_desc_d  = trans_desc_q;
      trans_id_d    = trans_id_q;
      req_done_d    = '0;
`ifdef HYPER_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_d     = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               trans_desc_d  = desc_arr[win_idx];
               trans_id_d    = win_idx;
               trans_valid_d = 1'b1;
               state_d       = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (trans_ready_i) begin
               trans_valid_d = 1'b0;
               state_d       = ST_BUSY;
`ifdef HYPER_ARB_TIMEOUT_EN
               cnt_d         = '0;
`endif
            end
         end

         ST_BUSY: begin
            if (trans_done_i) begin
               req_done_d[trans_id_q] = 1'b1;
               last_grant_d           = trans_id_q;
               state_d                = ST_IDLE;
`ifdef HYPER_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_LAST) begin
               cnt_d                  = cnt_q + CNT_W'(1);
               timeout_d              = 1'b1;
               req_done_d[trans_id_q] = 1'b1;
               last_grant_d           = trans_id_q;
               state_d                = ST_IDLE;
            end else begin
               cnt_d                  = cnt_q + CNT_W'(1);
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset aborts any transaction in flight
   // without a done pulse. It also points the round-robin pointer at the
   // last requester, so requester 0 is served first afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= ID_WIDTH'(NB_CH - 1);
         trans_valid_q <= 1'b0;
         trans_desc_q  <= '0;
         trans_id_q    <= '0;
         req_done_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         trans_valid_q <= trans_valid_d;
         trans_desc_q  <= trans_desc_d;
         trans_id_q    <= trans_id_d;
         req_done_q    <= req_done_d;
      end
   end

`ifdef HYPER_ARB_TIMEOUT_EN
   // Watchdog registers. The counter only counts cycles spent in BUSY, and
   // is cleared on each entry into BUSY.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign trans_valid_o = trans_valid_q;
   assign trans_desc_o  = trans_desc_q;
   assign trans_id_o    = trans_id_q;
   assign req_done_o    = req_done_q;
   assign busy_o        = (state_q == ST_ISSUE) || (state_q == ST_BUSY);

endmodule
